// File: rtl/ether_rx_if.sv
// RMII receive side plus dibit-stream output of the frame receiver.
// The slave modport is the receiver itself; master is whoever feeds it.
interface ether_rx_if;
   logic       crsdv;
   logic [1:0] rxd;
   logic       axiov;
   logic [1:0] axiod;
   logic       sof;
   logic       err;

   modport master (
      output crsdv, rxd,
      input  axiov, axiod, sof, err
   );

   modport slave (
      input  crsdv, rxd,
      output axiov, axiod, sof, err
   );
endinterface

// File: rtl/ether_rx.sv
// RMII frame receiver: strips preamble/SFD and forwards DA..FCS dibits with
// one cycle latency; flags bad preambles and over-length frames on err.
module ether_rx #(
   parameter int MIN_PREAMBLE = 8,
   parameter int MAX_DIBITS   = 6088
) (
   input logic         clk,
   input logic         rst_n,
   ether_rx_if.slave   bus
);

   localparam logic [4:0]  MIN_PRE_L = 5'(MIN_PREAMBLE);
   localparam logic [12:0] MAX_DIB_L = 13'(MAX_DIBITS);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  pre_cnt_reg, pre_cnt_next;
   logic [12:0] dib_cnt_reg, dib_cnt_next;
   logic        armed_reg, armed_next;
   logic        axiov_reg, axiov_next;
   logic [1:0]  axiod_reg, axiod_next;
   logic        sof_reg, sof_next;
   logic        err_reg, err_next;

   logic sfd_ok;
   logic room;

   assign sfd_ok = (bus.rxd == 2'b11) && (pre_cnt_reg >= MIN_PRE_L);
   assign room   = (dib_cnt_reg < MAX_DIB_L);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         pre_cnt_reg <= '0;
         dib_cnt_reg <= '0;
         armed_reg   <= 1'b0;
         axiov_reg   <= 1'b0;
         axiod_reg   <= 2'b00;
         sof_reg     <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pre_cnt_reg <= pre_cnt_next;
         dib_cnt_reg <= dib_cnt_next;
         armed_reg   <= armed_next;
         axiov_reg   <= axiov_next;
         axiod_reg   <= axiod_next;
         sof_reg     <= sof_next;
         err_reg     <= err_next;
      end
   end

   // armed stays low after reset until the line is seen idle, so a reset
   // released in the middle of a frame never locks onto payload bits.
   always_comb begin
      state_next   = state_reg;
      pre_cnt_next = pre_cnt_reg;
      dib_cnt_next = dib_cnt_reg;
      armed_next   = armed_reg | ~bus.crsdv;
      unique case (state_reg)
         IDLE: begin
            if (bus.crsdv) begin
               if (armed_reg && bus.rxd == 2'b01) begin
                  state_next   = PREAMBLE;
                  pre_cnt_next = 5'd1;
               end else begin
                  state_next = DROP;
               end
            end
         end
         PREAMBLE: begin
            if (!bus.crsdv) begin
               state_next = IDLE;
            end else if (bus.rxd == 2'b01) begin
               if (pre_cnt_reg != 5'd31) pre_cnt_next = pre_cnt_reg + 5'd1;
            end else if (sfd_ok) begin
               state_next   = DATA;
               dib_cnt_next = '0;
            end else begin
               state_next = DROP;
            end
         end
         DATA: begin
            if (!bus.crsdv) begin
               state_next = IDLE;
            end else if (room) begin
               dib_cnt_next = dib_cnt_reg + 13'd1;
            end else begin
               state_next = DROP;
            end
         end
         DROP: begin
            if (!bus.crsdv) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      axiov_next = 1'b0;
      axiod_next = 2'b00;
      sof_next   = 1'b0;
      err_next   = 1'b0;
      if (bus.crsdv) begin
         if (state_reg == DATA) begin
            if (room) begin
               axiov_next = 1'b1;
               axiod_next = bus.rxd;
               sof_next   = (dib_cnt_reg == 13'd0);
            end else begin
               err_next = 1'b1;
            end
         end else if (state_reg == PREAMBLE) begin
            err_next = (bus.rxd != 2'b01) && !sfd_ok;
         end
      end
   end

   assign bus.axiov = axiov_reg;
   assign bus.axiod = axiod_reg;
   assign bus.sof   = sof_reg;
   assign bus.err   = err_reg;

endmodule

// File: tb/tb_ether_rx.sv
// Directed bursts for ether_rx; each burst is parsed as a whole by a
// frame-level model and every output cycle is compared against it.
module tb_ether_rx;

   localparam int MIN = 8;
   localparam int MAX = 6088;

   typedef struct packed {
      logic       v;
      logic [1:0] d;
      logic       s;
      logic       e;
   } out_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ether_rx_if bus();

   ether_rx #(.MIN_PREAMBLE(MIN), .MAX_DIBITS(MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad = 0;
   int v_cnt = 0, s_cnt = 0, e_cnt = 0;
   int v0 = 0, s0 = 0, e0 = 0;
   int cyc = 0;
   out_t exp_q[$];
   logic [1:0] burst[$];

   initial begin : compare
      out_t want;
      out_t got;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {bus.axiov, bus.axiod, bus.sof, bus.err};
            total++;
            if (got !== want) begin
               bad++;
               $display("FAIL out_cycle cyc=%0d got v=%b d=%b sof=%b err=%b want v=%b d=%b sof=%b err=%b",
                        cyc, got.v, got.d, got.s, got.e, want.v, want.d, want.s, want.e);
            end
         end
         if (bus.axiov === 1'b1) v_cnt++;
         if (bus.sof === 1'b1) s_cnt++;
         if (bus.err === 1'b1) e_cnt++;
      end
   end

   task automatic lit(input string name, input int act, input int want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic build(input int npre, input logic [1:0] sfd, input int npay, input int seed);
      burst.delete();
      repeat (npre) burst.push_back(2'b01);
      burst.push_back(sfd);
      for (int j = 0; j < npay; j++) burst.push_back(2'((j * seed + j / 3 + seed) % 4));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.crsdv = 1'b0;
         bus.rxd   = 2'b00;
         exp_q.push_back('0);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Frame-level model: leading 01 run, then SFD check, then payload cap.
   task automatic send(input string name, input int gap, input int rst_at);
      int n;
      int n01;
      out_t ex[$];
      n = burst.size();
      n01 = 0;
      for (int p = 0; p < n; p++) ex.push_back('0);
      while (n01 < n && burst[n01] == 2'b01) n01++;
      if (n01 > 0 && n01 < n) begin
         if (burst[n01] == 2'b11 && n01 >= MIN) begin
            for (int p = n01 + 1; p < n; p++) begin
               int j;
               j = p - n01 - 1;
               if (j < MAX) ex[p] = {1'b1, burst[p], (j == 0), 1'b0};
               else if (j == MAX) ex[p] = {1'b0, 2'b00, 1'b0, 1'b1};
            end
         end else begin
            ex[n01] = {1'b0, 2'b00, 1'b0, 1'b1};
         end
      end
      if (rst_at >= 0)
         for (int p = rst_at; p < n; p++) ex[p] = '0;
      $display("burst %s: %0d dibits, preamble run %0d, gap %0d", name, n, n01, gap);
      for (int p = 0; p < n; p++) begin
         @(negedge clk);
         bus.crsdv = 1'b1;
         bus.rxd   = burst[p];
         if (p == rst_at) begin
            lit("axiov_before_reset", int'(bus.axiov), 1);
            rst_n = 1'b0;
            #1;
            lit("reset_drops_axiov", int'(bus.axiov), 0);
            lit("reset_no_err", int'(bus.err), 0);
         end else if (rst_at >= 0 && p == rst_at + 1) begin
            rst_n = 1'b1;
         end
         exp_q.push_back(ex[p]);
      end
      idle(gap);
   endtask

   task automatic counts(input string name, input int dv, input int ds, input int de);
      settle();
      lit({name, "_axiov_cycles"}, v_cnt - v0, dv);
      lit({name, "_sof_pulses"}, s_cnt - s0, ds);
      lit({name, "_err_pulses"}, e_cnt - e0, de);
      v0 = v_cnt;
      s0 = s_cnt;
      e0 = e_cnt;
   endtask

   initial begin : stim
      bus.crsdv = 1'b0;
      bus.rxd   = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      lit("reset_outputs", int'({bus.axiov, bus.axiod, bus.sof, bus.err}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      counts("post_reset", 0, 0, 0);

      build(31, 2'b11, 64, 3);
      send("long_preamble_64", 3, -1);
      counts("long_preamble_64", 64, 1, 0);

      build(MIN - 1, 2'b11, 10, 5);
      send("short_by_one", 2, -1);
      counts("short_by_one", 0, 0, 1);

      build(MIN, 2'b11, 12, 7);
      send("exact_min", 2, -1);
      counts("exact_min", 12, 1, 0);

      build(4, 2'b11, 10, 1);
      send("four_preamble", 2, -1);
      counts("four_preamble", 0, 0, 1);
      build(8, 2'b11, 16, 9);
      send("after_short", 2, -1);
      counts("after_short", 16, 1, 0);

      burst.delete();
      repeat (5) burst.push_back(2'b01);
      burst.push_back(2'b00);
      repeat (3) burst.push_back(2'b01);
      burst.push_back(2'b11);
      for (int j = 0; j < 10; j++) burst.push_back(2'(j % 4));
      send("preamble_00", 2, -1);
      counts("preamble_00", 0, 0, 1);
      build(8, 2'b11, 20, 2);
      send("after_00", 2, -1);
      counts("after_00", 20, 1, 0);

      burst.delete();
      repeat (6) burst.push_back(2'b01);
      send("preamble_only", 2, -1);
      build(0, 2'b11, 6, 3);
      send("starts_with_11", 2, -1);
      counts("no_frame", 0, 0, 0);

      build(8, 2'b11, 20, 11);
      send("b2b_first", 1, -1);
      build(8, 2'b11, 30, 13);
      send("b2b_second", 2, -1);
      counts("back_to_back", 50, 2, 0);

      build(8, 2'b11, 6100, 17);
      send("oversize_6100", 3, -1);
      counts("oversize_6100", MAX, 1, 1);

      build(8, 2'b11, MAX, 19);
      send("exact_max", 3, -1);
      counts("exact_max", MAX, 1, 0);

      build(8, 2'b11, 64, 23);
      send("reset_mid_frame", 3, 8 + 1 + 20);
      counts("reset_mid_frame", 20, 1, 0);
      build(8, 2'b11, 24, 29);
      send("after_reset", 3, -1);
      counts("after_reset", 24, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
